aes_round_ctrl: RTL and testbench

Sequencer for the iterative AES round datapath inside the AES HWPE engine. It takes 128-bit plaintext blocks from the source stream and drives the datapath through the initial AddRoundKey, rounds 1..Nr-1 and the final round (no MixColumns). It requests round keys from the key schedule by index and hands ciphertext to the sink stream. Sits between the HWPE streamer (plaintext source / ciphertext sink) and the round datapath, and is started by the top-level AES FSM.

---
 rtl/aes_round_ctrl_pkg.sv | 32 +++
 rtl/aes_round_ctrl.sv | 115 +++++++++++
 tb/tb_aes_round_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/aes_round_ctrl_pkg.sv
// Shared types and round-count helpers for the AES round sequencer.
package aes_package;

  typedef enum logic [1:0] {
    AES_KEY_128  = 2'b00,
    AES_KEY_192  = 2'b01,
    AES_KEY_256  = 2'b10,
    AES_KEY_RSVD = 2'b11
  } aes_key_len_t;

  typedef enum logic [2:0] {
    RCTL_IDLE,
    RCTL_WAIT_PT,
    RCTL_ROUND,
    RCTL_OUT,
    RCTL_DONE
  } aes_rctl_state_t;

  localparam int unsigned AES_NR_128 = 10;
  localparam int unsigned AES_NR_192 = 12;
  localparam int unsigned AES_NR_256 = 14;

  // Reserved length maps to the AES-128 count; such a job never reaches ROUND.
  function automatic logic [3:0] aes_nr(aes_key_len_t kl);
    case (kl)
      AES_KEY_192: return 4'(AES_NR_192);
      AES_KEY_256: return 4'(AES_NR_256);
      default:     return 4'(AES_NR_128);
    endcase
  endfunction

endpackage

// File: rtl/aes_round_ctrl.sv
// Iterative AES round sequencer: plaintext load, Nr rounds, ciphertext handoff,
// repeated for n_blocks blocks per job.
module aes_round_ctrl
  import aes_package::*;
#(
  parameter int CNT_W    = 32,
  parameter int RK_IDX_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                start_i,
  input  logic [1:0]          key_len_i,
  input  logic [CNT_W-1:0]    n_blocks_i,
  input  logic                pt_valid_i,
  output logic                pt_ready_o,
  output logic                ct_valid_o,
  input  logic                ct_ready_i,
  output logic [RK_IDX_W-1:0] rk_idx_o,
  input  logic                rk_valid_i,
  output logic                dp_load_o,
  output logic                dp_round_en_o,
  output logic                dp_final_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  output logic [CNT_W-1:0]    blk_cnt_o
);

  aes_rctl_state_t     r_state, w_state_nxt;
  aes_key_len_t        r_key_len;
  logic [CNT_W-1:0]    r_n_blocks, r_blk_cnt, w_blk_cnt_inc;
  logic [RK_IDX_W-1:0] r_round_cnt, w_nr;
  logic                r_err;
  logic                w_start, w_pt_hs, w_ct_hs, w_last_round;

  assign w_nr          = RK_IDX_W'(aes_nr(r_key_len));
  assign w_blk_cnt_inc = r_blk_cnt + CNT_W'(1);
  assign w_last_round  = (r_round_cnt == w_nr);
  assign w_start       = (r_state == RCTL_IDLE) && start_i;
  assign w_pt_hs       = (r_state == RCTL_WAIT_PT) && pt_valid_i && rk_valid_i;
  assign w_ct_hs       = (r_state == RCTL_OUT) && ct_ready_i;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_state     <= RCTL_IDLE;
      r_round_cnt <= '0;
      r_blk_cnt   <= '0;
      r_err       <= 1'b0;
      r_key_len   <= AES_KEY_128;
      r_n_blocks  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_blk_cnt  <= '0;
        r_err      <= (key_len_i == 2'b11);
        r_key_len  <= aes_key_len_t'(key_len_i);
        r_n_blocks <= n_blocks_i;
      end
      if (w_pt_hs)
        r_round_cnt <= RK_IDX_W'(1);
      else if (r_state == RCTL_ROUND && rk_valid_i && !w_last_round)
        r_round_cnt <= r_round_cnt + RK_IDX_W'(1);
      if (w_ct_hs)
        r_blk_cnt <= w_blk_cnt_inc;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    pt_ready_o    = 1'b0;
    ct_valid_o    = 1'b0;
    rk_idx_o      = '0;
    dp_load_o     = 1'b0;
    dp_round_en_o = 1'b0;
    dp_final_o    = 1'b0;
    done_o        = 1'b0;
    case (r_state)
      RCTL_IDLE: begin
        if (start_i) begin
          if (key_len_i == 2'b11)    w_state_nxt = RCTL_DONE;
          else if (n_blocks_i == '0) w_state_nxt = RCTL_DONE;
          else                       w_state_nxt = RCTL_WAIT_PT;
        end
      end
      RCTL_WAIT_PT: begin
        // rk[0] must be present for the load, so readiness follows the key schedule.
        pt_ready_o = rk_valid_i;
        dp_load_o  = w_pt_hs;
        if (w_pt_hs) w_state_nxt = RCTL_ROUND;
      end
      RCTL_ROUND: begin
        rk_idx_o      = r_round_cnt;
        dp_round_en_o = rk_valid_i;
        dp_final_o    = w_last_round;
        if (rk_valid_i && w_last_round) w_state_nxt = RCTL_OUT;
      end
      RCTL_OUT: begin
        ct_valid_o = 1'b1;
        if (ct_ready_i)
          w_state_nxt = (w_blk_cnt_inc == r_n_blocks) ? RCTL_DONE : RCTL_WAIT_PT;
      end
      RCTL_DONE: begin
        done_o      = 1'b1;
        w_state_nxt = RCTL_IDLE;
      end
      default: w_state_nxt = RCTL_IDLE;
    endcase
  end

  assign busy_o    = (r_state != RCTL_IDLE);
  assign err_o     = r_err;
  assign blk_cnt_o = r_blk_cnt;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl with a ciphertext-latency scoreboard.
module tb_aes_round_ctrl;
  localparam int CNT_W    = 32;
  localparam int RK_IDX_W = 4;

  logic                clk = 1'b0;
  logic                reset, clear, start_i;
  logic [1:0]          key_len_i;
  logic [CNT_W-1:0]    n_blocks_i;
  logic                pt_valid_i, pt_ready_o, ct_valid_o, ct_ready_i;
  logic [RK_IDX_W-1:0] rk_idx_o;
  logic                rk_valid_i, dp_load_o, dp_round_en_o, dp_final_o;
  logic                busy_o, done_o, err_o;
  logic [CNT_W-1:0]    blk_cnt_o;

  aes_round_ctrl #(.CNT_W(CNT_W), .RK_IDX_W(RK_IDX_W)) dut (
    .clk(clk), .reset(reset), .clear(clear), .start_i(start_i),
    .key_len_i(key_len_i), .n_blocks_i(n_blocks_i),
    .pt_valid_i(pt_valid_i), .pt_ready_o(pt_ready_o),
    .ct_valid_o(ct_valid_o), .ct_ready_i(ct_ready_i),
    .rk_idx_o(rk_idx_o), .rk_valid_i(rk_valid_i),
    .dp_load_o(dp_load_o), .dp_round_en_o(dp_round_en_o), .dp_final_o(dp_final_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .blk_cnt_o(blk_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct { int ct_cyc; int blk; } exp_t;
  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc   = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Returns 1 ns after the rising edge; inputs are driven here, outputs sampled 1 ns later.
  task automatic step();
    @(posedge clk); #1; cyc++;
  endtask

  task automatic start_job(input logic [1:0] kl, input int nb);
    key_len_i = kl; n_blocks_i = nb; start_i = 1'b1;
    step();
    start_i = 1'b0;
    key_len_i = ~kl;             // config must already be latched
    n_blocks_i = nb + 5;
  endtask

  task automatic run_job(input logic [1:0] kl, input int nb, input int rk_stall_round,
                         input int rk_stall_len, input int ct_stall_len);
    int  nr;
    int  strobes, finals, rk_left, ct_left, ct_hs_cnt, pt_hs_cnt;
    int  last_ct_hs, next_pt_exp, held_blk, stall_add;
    bit  in_out, got_done;
    exp_t e;
    nr = (kl == 2'b00) ? 10 : (kl == 2'b01) ? 12 : 14;
    strobes = 0; finals = 0; rk_left = rk_stall_len; ct_left = ct_stall_len;
    ct_hs_cnt = 0; pt_hs_cnt = 0; last_ct_hs = -1; held_blk = 0;
    in_out = 1'b0; got_done = 1'b0;
    start_job(kl, nb);
    next_pt_exp = cyc;
    pt_valid_i = 1'b1;
    for (int k = 0; k < 800 && !got_done; k++) begin
      rk_valid_i = 1'b1;
      if (pt_hs_cnt == 1 && rk_left > 0 && rk_idx_o == rk_stall_round) begin
        rk_valid_i = 1'b0; rk_left--;
      end
      ct_ready_i = 1'b1;
      if (ct_valid_o && ct_left > 0) begin ct_ready_i = 1'b0; ct_left--; end
      #1;
      chk("pt_ct_excl", pt_ready_o & ct_valid_o, 0);
      chk("load_only_on_hs", dp_load_o, pt_valid_i & pt_ready_o);
      chk("no_strobe_when_stalled", dp_round_en_o & ~rk_valid_i, 0);
      if (in_out && !ct_valid_o) chk("ct_valid_held", 0, 1);
      if (dp_round_en_o) begin
        strobes++;
        chk("final_at_nr", dp_final_o, rk_idx_o == nr);
        if (dp_final_o) finals++;
      end
      if (pt_valid_i && pt_ready_o) begin
        chk("pt_hs_cycle", cyc, next_pt_exp);
        stall_add = (pt_hs_cnt == 0 && rk_stall_round > 0) ? rk_stall_len : 0;
        e.ct_cyc = cyc + nr + 1 + stall_add;
        e.blk = pt_hs_cnt;
        sb.push_back(e);
        pt_hs_cnt++; strobes = 0; finals = 0;
      end
      if (ct_valid_o && !in_out) begin
        in_out = 1'b1; held_blk = blk_cnt_o;
        if (sb.size() == 0) chk("sb_underflow", 1, 0);
        else chk("ct_latency", cyc, sb[0].ct_cyc);
        chk("round_strobes", strobes, nr);
        chk("final_strobes", finals, 1);
      end
      if (ct_valid_o && !ct_ready_i) begin
        chk("blk_cnt_stalled", blk_cnt_o, held_blk);
        chk("pt_ready_stalled", pt_ready_o, 0);
      end
      if (ct_valid_o && ct_ready_i) begin
        if (sb.size() != 0) begin
          chk("blk_cnt_at_ct", blk_cnt_o, sb[0].blk);
          void'(sb.pop_front());
        end
        in_out = 1'b0; ct_left = ct_stall_len; ct_hs_cnt++;
        last_ct_hs = cyc; next_pt_exp = cyc + 1;
      end
      if (done_o) begin
        got_done = 1'b1;
        chk("done_cycle", cyc, last_ct_hs + 1);
        chk("blk_cnt_done", blk_cnt_o, nb);
        chk("ct_count", ct_hs_cnt, nb);
        chk("err_clean", err_o, 0);
        chk("sb_drained", sb.size(), 0);
      end
      step();
    end
    if (!got_done) chk("job_timeout", 0, 1);
    pt_valid_i = 1'b0; rk_valid_i = 1'b1; ct_ready_i = 1'b1;
    #1;
    chk("idle_busy", busy_o, 0);
    chk("done_one_cycle", done_o, 0);
    step(); #1;
    chk("blk_cnt_hold", blk_cnt_o, nb);
    sb.delete();
  endtask

  initial begin
    bit found;
    reset = 1'b1; clear = 1'b0; start_i = 1'b0; key_len_i = '0; n_blocks_i = '0;
    pt_valid_i = 1'b0; ct_ready_i = 1'b1; rk_valid_i = 1'b1;
    repeat (3) step();
    reset = 1'b0; #1;
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_blk", blk_cnt_o, 0);
    chk("rst_pt_ready", pt_ready_o, 0);
    chk("rst_ct_valid", ct_valid_o, 0);
    chk("rst_rk_idx", rk_idx_o, 0);
    chk("rst_strobes", {dp_load_o, dp_round_en_o, dp_final_o}, 0);
    step();

    run_job(2'b00, 1, -1, 0, 0);   // AES-128 single block
    run_job(2'b10, 3, -1, 0, 0);   // AES-256 back-to-back
    run_job(2'b01, 1, 5, 3, 0);    // AES-192, key schedule stall at round 5
    run_job(2'b00, 2, -1, 0, 4);   // sink backpressure in OUT

    // Reserved key length: error and immediate done, no plaintext accepted.
    pt_valid_i = 1'b1;
    key_len_i = 2'b11; n_blocks_i = 4; start_i = 1'b1; #1;
    chk("rsvd_start_pt_ready", pt_ready_o, 0);
    step(); start_i = 1'b0; #1;
    chk("rsvd_done", done_o, 1);
    chk("rsvd_err", err_o, 1);
    chk("rsvd_pt_ready", pt_ready_o, 0);
    step(); #1;
    chk("rsvd_idle", busy_o, 0);
    chk("rsvd_err_sticky", err_o, 1);
    chk("rsvd_pt_ready_idle", pt_ready_o, 0);

    // Zero-block job clears the error and finishes empty.
    key_len_i = 2'b00; n_blocks_i = 0; start_i = 1'b1;
    step(); start_i = 1'b0; #1;
    chk("nb0_done", done_o, 1);
    chk("nb0_err", err_o, 0);
    chk("nb0_blk", blk_cnt_o, 0);
    chk("nb0_pt_ready", pt_ready_o, 0);
    step(); pt_valid_i = 1'b0; #1;
    chk("nb0_idle", busy_o, 0);

    // Clear during round 4 aborts the job.
    start_job(2'b00, 2);
    pt_valid_i = 1'b1; rk_valid_i = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      #1;
      if (dp_round_en_o && rk_idx_o == 4) found = 1'b1;
      else step();
    end
    chk("clear_reached_r4", found, 1);
    clear = 1'b1;
    step(); clear = 1'b0; pt_valid_i = 1'b0; #1;
    chk("clr_busy", busy_o, 0);
    chk("clr_rk_idx", rk_idx_o, 0);
    chk("clr_strobes", {dp_load_o, dp_round_en_o, dp_final_o}, 0);
    chk("clr_hs", {pt_ready_o, ct_valid_o, done_o}, 0);
    chk("clr_blk_err", {err_o, blk_cnt_o}, 0);
    step();
    run_job(2'b00, 1, -1, 0, 0);   // full job after abort

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
